// File: rtl/return_addr_stack_if.sv
// Bundle between the control unit and the return-address stack.
// The control unit drives the master side; the stack is the slave.
interface return_addr_stack_if #(
    parameter int unsigned AW    = 8,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = 3
);
    logic             push_en;
    logic [AW-1:0]    push_addr;
    logic             pop_en;
    logic             clr_err;
    logic [AW-1:0]    ret_addr;
    logic             ret_valid;
    logic [AW-1:0]    top_addr;
    logic [PTR_W:0]   count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    modport master (
        output push_en, push_addr, pop_en, clr_err,
        input  ret_addr, ret_valid, top_addr, count, empty, full, overflow, underflow
    );

    modport slave (
        input  push_en, push_addr, pop_en, clr_err,
        output ret_addr, ret_valid, top_addr, count, empty, full, overflow, underflow
    );
endinterface

// File: rtl/return_addr_stack.sv
// Return-address stack: CALL pushes a PC, RET pops it with one cycle of latency.
// Define RAS_WRAP_EN to make a push while full overwrite the oldest entry.
module return_addr_stack #(
    parameter int unsigned AW    = 8,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    return_addr_stack_if.slave   bus
);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [AW-1:0]    r_mem [DEPTH];
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W:0]   r_count;
    logic [AW-1:0]    r_ret_addr;
    logic             r_ret_valid;
    logic             r_ovf;
    logic             r_udf;

    logic [PTR_W-1:0] w_ptr_nxt;
    logic [PTR_W:0]   w_count_nxt;
    logic [AW-1:0]    w_ret_addr_nxt;
    logic             w_ret_valid_nxt;
    logic             w_ovf_set;
    logic             w_udf_set;
    logic             w_wr_en;
    logic [PTR_W-1:0] w_wr_idx;
    logic [PTR_W-1:0] w_top_idx;
    logic             w_empty;
    logic             w_full;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_FULL);
    assign w_top_idx = r_ptr - PTR_ONE;

    always_comb begin
        w_ptr_nxt       = r_ptr;
        w_count_nxt     = r_count;
        w_ret_addr_nxt  = r_ret_addr;
        w_ret_valid_nxt = 1'b0;
        w_ovf_set       = 1'b0;
        w_udf_set       = 1'b0;
        w_wr_en         = 1'b0;
        w_wr_idx        = r_ptr;
        case ({bus.push_en, bus.pop_en})
            2'b10: begin
                if (!w_full) begin
                    w_wr_en     = 1'b1;
                    w_ptr_nxt   = r_ptr + PTR_ONE;
                    w_count_nxt = r_count + CNT_ONE;
                end else begin
                    w_ovf_set = 1'b1;
`ifdef RAS_WRAP_EN
                    // When full, ptr already points at the oldest slot.
                    w_wr_en   = 1'b1;
                    w_ptr_nxt = r_ptr + PTR_ONE;
`endif
                end
            end
            2'b01: begin
                if (!w_empty) begin
                    w_ret_addr_nxt  = r_mem[w_top_idx];
                    w_ret_valid_nxt = 1'b1;
                    w_ptr_nxt       = w_top_idx;
                    w_count_nxt     = r_count - CNT_ONE;
                end else begin
                    w_udf_set = 1'b1;
                end
            end
            2'b11: begin
                w_ret_valid_nxt = 1'b1;
                if (!w_empty) begin
                    // RET followed by CALL: replace the top in place.
                    w_ret_addr_nxt = r_mem[w_top_idx];
                    w_wr_en        = 1'b1;
                    w_wr_idx       = w_top_idx;
                end else begin
                    w_ret_addr_nxt = bus.push_addr;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr       <= '0;
            r_count     <= '0;
            r_ret_addr  <= '0;
            r_ret_valid <= 1'b0;
            r_ovf       <= 1'b0;
            r_udf       <= 1'b0;
        end else begin
            r_ptr       <= w_ptr_nxt;
            r_count     <= w_count_nxt;
            r_ret_addr  <= w_ret_addr_nxt;
            r_ret_valid <= w_ret_valid_nxt;
            r_ovf       <= w_ovf_set | (r_ovf & ~bus.clr_err);
            r_udf       <= w_udf_set | (r_udf & ~bus.clr_err);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_idx] <= bus.push_addr;
        end
    end

    assign bus.ret_addr  = r_ret_addr;
    assign bus.ret_valid = r_ret_valid;
    assign bus.top_addr  = w_empty ? '0 : r_mem[w_top_idx];
    assign bus.count     = r_count;
    assign bus.empty     = w_empty;
    assign bus.full      = w_full;
    assign bus.overflow  = r_ovf;
    assign bus.underflow = r_udf;
endmodule

// File: tb/tb_return_addr_stack.sv
// Bench for return_addr_stack: a queue-based stack model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_return_addr_stack;
    localparam int unsigned AW    = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned PTR_W = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    return_addr_stack_if #(.AW(AW), .DEPTH(DEPTH), .PTR_W(PTR_W)) bus ();

    return_addr_stack #(.AW(AW), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    logic [7:0] stk[$];
    logic [7:0] m_ret_addr  = 8'h00;
    logic       m_ret_valid = 1'b0;
    logic       m_ovf       = 1'b0;
    logic       m_udf       = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stack semantics expressed directly on a queue; back of queue is the top.
    task automatic model_step();
        bit set_o, set_u, v;
        logic [7:0] ra;
        if (rst) begin
            stk.delete();
            m_ret_addr  = 8'h00;
            m_ret_valid = 1'b0;
            m_ovf       = 1'b0;
            m_udf       = 1'b0;
        end else begin
            set_o = 0; set_u = 0; v = 0; ra = m_ret_addr;
            if (bus.push_en && bus.pop_en) begin
                v = 1;
                if (stk.size() > 0) begin
                    ra = stk[stk.size() - 1];
                    stk[stk.size() - 1] = bus.push_addr;
                end else begin
                    ra = bus.push_addr;
                end
            end else if (bus.push_en) begin
                if (stk.size() < DEPTH) begin
                    stk.push_back(bus.push_addr);
                end else begin
                    set_o = 1;
`ifdef RAS_WRAP_EN
                    void'(stk.pop_front());
                    stk.push_back(bus.push_addr);
`endif
                end
            end else if (bus.pop_en) begin
                if (stk.size() > 0) begin
                    ra = stk.pop_back();
                    v  = 1;
                end else begin
                    set_u = 1;
                end
            end
            m_ret_valid = v;
            m_ret_addr  = ra;
            m_ovf = set_o | (m_ovf & ~bus.clr_err);
            m_udf = set_u | (m_udf & ~bus.clr_err);
        end
    endtask

    always @(posedge clk or posedge rst) model_step();

    always @(negedge clk) begin
        if (started && !rst) begin
            check("ret_valid", {31'd0, bus.ret_valid}, {31'd0, m_ret_valid});
            check("ret_addr", {24'd0, bus.ret_addr}, {24'd0, m_ret_addr});
            check("top_addr", {24'd0, bus.top_addr},
                  (stk.size() > 0) ? {24'd0, stk[stk.size() - 1]} : 32'd0);
            check("count", {28'd0, bus.count}, stk.size());
            check("empty", {31'd0, bus.empty}, {31'd0, stk.size() == 0});
            check("full", {31'd0, bus.full}, {31'd0, stk.size() == DEPTH});
            check("overflow", {31'd0, bus.overflow}, {31'd0, m_ovf});
            check("underflow", {31'd0, bus.underflow}, {31'd0, m_udf});
        end
    end

    task automatic cyc(input logic push, input logic [7:0] a, input logic pop, input logic clr);
        bus.push_en   = push;
        bus.push_addr = a;
        bus.pop_en    = pop;
        bus.clr_err   = clr;
        @(posedge clk);
        #1;
        bus.push_en = 1'b0;
        bus.pop_en  = 1'b0;
        bus.clr_err = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        started = 1'b1;
    endtask

    initial begin
        bus.push_en = 1'b0; bus.push_addr = 8'h00; bus.pop_en = 1'b0; bus.clr_err = 1'b0;
        @(posedge clk);
        #1;

        // 1: LIFO order of three pushes
        do_reset();
        check("rst_count", {28'd0, bus.count}, 32'd0);
        check("rst_empty", {31'd0, bus.empty}, 32'd1);
        check("rst_ret_valid", {31'd0, bus.ret_valid}, 32'd0);
        check("rst_ret_addr", {24'd0, bus.ret_addr}, 32'h00);
        cyc(1, 8'h10, 0, 0);
        cyc(1, 8'h20, 0, 0);
        cyc(1, 8'h30, 0, 0);
        check("t1_count3", {28'd0, bus.count}, 32'd3);
        check("t1_top", {24'd0, bus.top_addr}, 32'h30);
        cyc(0, 8'h00, 1, 0);
        check("t1_pop1", {24'd0, bus.ret_addr}, 32'h30);
        check("t1_pop1_v", {31'd0, bus.ret_valid}, 32'd1);
        check("t1_model_pop1", {24'd0, m_ret_addr}, 32'h30);
        check("t1_count2", {28'd0, bus.count}, 32'd2);
        cyc(0, 8'h00, 1, 0);
        check("t1_pop2", {24'd0, bus.ret_addr}, 32'h20);
        cyc(0, 8'h00, 1, 0);
        check("t1_pop3", {24'd0, bus.ret_addr}, 32'h10);
        check("t1_count0", {28'd0, bus.count}, 32'd0);
        check("t1_empty", {31'd0, bus.empty}, 32'd1);
        check("t1_flags", {30'd0, bus.overflow, bus.underflow}, 32'd0);
        cyc(0, 8'h00, 0, 0);
        check("t1_pulse_end", {31'd0, bus.ret_valid}, 32'd0);

        // 3: underflow, clear, set-beats-clear
        do_reset();
        cyc(0, 8'h00, 1, 0);
        check("t3_udf", {31'd0, bus.underflow}, 32'd1);
        check("t3_no_valid", {31'd0, bus.ret_valid}, 32'd0);
        check("t3_ret_addr", {24'd0, bus.ret_addr}, 32'h00);
        cyc(0, 8'h00, 1, 1);
        check("t3_set_wins", {31'd0, bus.underflow}, 32'd1);
        cyc(0, 8'h00, 0, 1);
        check("t3_clr", {31'd0, bus.underflow}, 32'd0);

        // 2: fill, overflow, simultaneous push/pop while full, drain past empty
        do_reset();
        for (int i = 1; i <= 8; i++) cyc(1, 8'(i), 0, 0);
        check("t2_full", {31'd0, bus.full}, 32'd1);
        check("t2_count8", {28'd0, bus.count}, 32'd8);
        cyc(1, 8'h09, 0, 0);
        check("t2_ovf", {31'd0, bus.overflow}, 32'd1);
        check("t2_model_ovf", {31'd0, m_ovf}, 32'd1);
        check("t2_count_ovf", {28'd0, bus.count}, 32'd8);
        cyc(0, 8'h00, 1, 0);
`ifdef RAS_WRAP_EN
        check("t2_pop_after_ovf", {24'd0, bus.ret_addr}, 32'h09);
`else
        check("t2_pop_after_ovf", {24'd0, bus.ret_addr}, 32'h08);
`endif
        check("t2_count7", {28'd0, bus.count}, 32'd7);
        cyc(0, 8'h00, 0, 1);
        check("t2_ovf_clr", {31'd0, bus.overflow}, 32'd0);
        cyc(1, 8'hA0, 0, 0);
        cyc(1, 8'hB0, 1, 0);
        check("t2_pp_full_ret", {24'd0, bus.ret_addr}, 32'hA0);
        check("t2_pp_full_ovf", {31'd0, bus.overflow}, 32'd0);
        check("t2_pp_full_top", {24'd0, bus.top_addr}, 32'hB0);
        check("t2_pp_full_cnt", {28'd0, bus.count}, 32'd8);
        for (int i = 0; i < 9; i++) cyc(0, 8'h00, 1, 0);
        check("t2_drain_udf", {31'd0, bus.underflow}, 32'd1);

        // 4: push+pop on non-empty
        do_reset();
        cyc(1, 8'h40, 0, 0);
        cyc(1, 8'h55, 1, 0);
        check("t4_ret", {24'd0, bus.ret_addr}, 32'h40);
        check("t4_valid", {31'd0, bus.ret_valid}, 32'd1);
        check("t4_count", {28'd0, bus.count}, 32'd1);
        check("t4_top", {24'd0, bus.top_addr}, 32'h55);

        // 5: bypass on empty
        do_reset();
        cyc(1, 8'h77, 1, 0);
        check("t5_ret", {24'd0, bus.ret_addr}, 32'h77);
        check("t5_valid", {31'd0, bus.ret_valid}, 32'd1);
        check("t5_count", {28'd0, bus.count}, 32'd0);
        check("t5_udf", {31'd0, bus.underflow}, 32'd0);

        // 6: reset arrives with a pop in flight
        do_reset();
        cyc(1, 8'h11, 0, 0);
        cyc(1, 8'h22, 0, 0);
        cyc(0, 8'h00, 1, 0);
        bus.pop_en = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.pop_en = 1'b0;
        check("t6_valid", {31'd0, bus.ret_valid}, 32'd0);
        check("t6_count", {28'd0, bus.count}, 32'd0);
        check("t6_ret_addr", {24'd0, bus.ret_addr}, 32'h00);
        check("t6_flags", {30'd0, bus.overflow, bus.underflow}, 32'd0);
        check("t6_empty", {31'd0, bus.empty}, 32'd1);

        cyc(0, 8'h00, 0, 0);
        cyc(0, 8'h00, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/return_addr_stack.md
Name: return_addr_stack

Overview:
- Hardware return-address stack on the consuming side of the link path. CALL sequences push 8-bit return PCs; RET sequences pop them.
- Sits between the control unit and the PC-select mux. The control unit pulses `pop_en` on RET, and this block returns the saved address one cycle later.
- Supports nested calls up to DEPTH, with overflow/underflow detection and sticky error flags.

Parameters:
- AW, 8, address width of stored return PCs.
- DEPTH, 8, number of stack entries; power of two, minimum 2.
- PTR_W, 3, pointer width; must equal log2(DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- push_en  in  1  push push_addr this cycle (CALL).
- push_addr  in  AW  return address to save.
- pop_en  in  1  pop top entry this cycle (RET).
- clr_err  in  1  clears sticky overflow/underflow flags.
- ret_addr  out  AW  registered popped address.
- ret_valid  out  1  one-cycle pulse; ret_addr is valid.
- top_addr  out  AW  combinational view of the current top entry; 0 when empty.
- count  out  PTR_W+1  number of valid entries, 0..DEPTH.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- overflow  out  1  sticky; a push was attempted while full.
- underflow  out  1  sticky; a pop was attempted while empty.

Behaviour:
- Reset (async, on assertion):
  - count=0; write pointer=0.
  - ret_addr=0, ret_valid=0, overflow=0, underflow=0.
  - Storage array is not reset.
  - Reset mid-operation discards all entries and suppresses any pending ret_valid.
- Storage: DEPTH x AW register array. The write pointer points at the next free slot; the top entry is at pointer-1.
- Push only, not full: mem[ptr]<=push_addr; ptr+1; count+1. Visible on top_addr the next cycle.
- Push only, full: entry rejected; count, ptr and contents unchanged; overflow<=1.
- Pop only, not empty: ret_addr<=mem[ptr-1]; ret_valid<=1 next cycle; ptr-1; count-1.
  - Latency is 1 cycle from the pop_en edge to ret_valid.
- Pop only, empty: underflow<=1; ret_valid stays 0; ret_addr holds its previous value.
- Push and pop together, not empty (RET then immediate CALL):
  - ret_addr<=current top; ret_valid<=1.
  - That slot is overwritten with push_addr.
  - count and ptr are unchanged. No overflow even when full.
- Push and pop together, empty (bypass):
  - ret_addr<=push_addr; ret_valid<=1; count stays 0.
  - No underflow.
- ret_valid is a single-cycle pulse; it deasserts the cycle after unless another valid pop occurs.
- Back-to-back pops on consecutive cycles return consecutive entries, one per cycle.
- clr_err clears both sticky flags. If an error event occurs in the same cycle, the set wins.
- Pointer arithmetic is modulo DEPTH. count is kept separately so that full and empty are unambiguous.

Optional Feature:
- Macro: RAS_WRAP_EN.
- Defined: push while full (without pop) overwrites the oldest entry.
  - Circular buffer: ptr advances modulo DEPTH; count stays DEPTH.
  - overflow is still set to flag the lost entry.
  - Subsequent pops return the newest DEPTH addresses in LIFO order.
- Not defined: push while full is rejected as described in Behaviour.

Test Plan:
1. Reset, then push 0x10, 0x20, 0x30 on consecutive cycles, then pop three times -> ret_addr 0x30, 0x20, 0x10, each with a ret_valid pulse 1 cycle after its pop; count goes 3 -> 0; empty=1; no flags set.
2. Push 8 entries 0x01..0x08 (full=1), then push 0x09 -> without RAS_WRAP_EN: overflow=1, count=8, pop returns 0x08. With RAS_WRAP_EN: overflow=1, pops return 0x09 down to 0x02.
3. Pop from empty after reset -> underflow=1, ret_valid=0, ret_addr=0x00. Then assert clr_err -> underflow=0.
4. Stack holds 0x40; assert push_en=1 (0x55) and pop_en=1 in the same cycle -> ret_addr=0x40, ret_valid=1, count=1, top_addr=0x55.
5. Empty stack; push 0x77 and pop in the same cycle -> ret_addr=0x77, ret_valid=1, count=0, underflow=0.
6. Push 0x11 and 0x22; pop; assert rst in the cycle before ret_valid would appear -> ret_valid stays 0, count=0, ret_addr=0x00, flags cleared.
